// File: rtl/tms_loader_pkg.sv
// tms_loader_pkg: register map, bit indices, FSM states and address decode for wb_prog_loader
package tms_loader_pkg;

    localparam logic [23:0] CTRL_OFF  = 24'h01_0000;
    localparam logic [23:0] STAT_OFF  = 24'h01_0004;
    localparam int          CTRL_RUN  = 0;
    localparam int          STAT_RUN  = 0;
    localparam int          STAT_VIOL = 1;

    typedef enum logic [3:0] {IDLE, WR0, WR1, WR2, WR3, RD0, RD1, RD2, RD3, RDL, ACK} state_t;
    typedef enum logic [1:0] {REG_MEM, REG_CTRL, REG_STAT, REG_NONE} region_t;

    function automatic region_t decode(input logic [23:0] off, input int unsigned aw);
        return (off < (24'd1 << aw)) ? REG_MEM :
               (off == CTRL_OFF)     ? REG_CTRL :
               (off == STAT_OFF)     ? REG_STAT : REG_NONE;
    endfunction

endpackage

// File: rtl/wb_prog_loader.sv
// wb_prog_loader: Wishbone word-to-byte loader for the TMS1x00 program RAM, owns core reset
module wb_prog_loader
    import tms_loader_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              wb_clk_i,
    input  logic              resetb,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    output logic              core_rst_n_o
);

    state_t            state;
    region_t           rgn;
    logic              run, viol, alive, req;
    logic              bus_en, bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic [31:0]       wdat, rbuf, reg_rd;
    logic [3:0]        sel;
    logic [1:0]        nl;
    logic              unused_ok;

    assign req         = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign rgn         = decode(wbs_adr_i[23:0], ADDR_W);
    assign nl          = bus_addr[1:0] + 2'd1;
    assign unused_ok   = &{1'b0, wbs_adr_i[31:24]};
    // Once running, the fetch path owns the RAM port outright
    assign mem_en_o    = run | bus_en;
    assign mem_we_o    = ~run & bus_we;
    assign mem_addr_o  = run ? core_addr_i : bus_addr;
    assign mem_wdata_o = bus_wdata;

    always_comb begin
        reg_rd = '0;
        if (rgn == REG_CTRL) reg_rd[CTRL_RUN] = run;
        if (rgn == REG_STAT) begin
            reg_rd[STAT_RUN]  = run;
            reg_rd[STAT_VIOL] = viol;
        end
    end

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            state        <= IDLE;
            run          <= 1'b0;
            viol         <= 1'b0;
            alive        <= 1'b0;
            wdat         <= '0;
            rbuf         <= '0;
            sel          <= '0;
            bus_en       <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            core_rst_n_o <= 1'b0;
        end else begin
            core_rst_n_o <= run;
            alive        <= alive & wbs_cyc_i;
            case (state)
                IDLE: if (req) begin
                    alive <= 1'b1;
                    wdat  <= wbs_dat_i;
                    sel   <= wbs_sel_i;
                    if (rgn == REG_MEM && !run) begin
                        state     <= wbs_we_i ? WR0 : RD0;
                        bus_en    <= 1'b1;
                        bus_we    <= wbs_we_i & wbs_sel_i[0];
                        bus_addr  <= {wbs_adr_i[ADDR_W-1:2], 2'd0};
                        bus_wdata <= wbs_dat_i[7:0];
                    end else begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= reg_rd;
                        if (wbs_we_i && wbs_sel_i[0] && rgn == REG_CTRL) run <= wbs_dat_i[CTRL_RUN];
                        viol <= (rgn == REG_MEM) |
                                (viol & ~(wbs_we_i & wbs_sel_i[0] & (rgn == REG_STAT) & wbs_dat_i[STAT_VIOL]));
                    end
                end
                WR0, WR1, WR2: begin
                    state         <= state_t'(state + 4'd1);
                    bus_addr[1:0] <= nl;
                    bus_we        <= sel[nl];
                    bus_wdata     <= wdat[{nl, 3'b000} +: 8];
                end
                WR3: begin
                    state     <= ACK;
                    bus_en    <= 1'b0;
                    bus_we    <= 1'b0;
                    wbs_ack_o <= alive & wbs_cyc_i;
                end
                // RAM data lags the address by one cycle, so each read state captures the previous lane
                RD0, RD1, RD2: begin
                    state         <= state_t'(state + 4'd1);
                    bus_addr[1:0] <= nl;
                    rbuf          <= {mem_rdata_i, rbuf[31:8]};
                end
                RD3: begin
                    state  <= RDL;
                    bus_en <= 1'b0;
                    rbuf   <= {mem_rdata_i, rbuf[31:8]};
                end
                RDL: begin
                    state     <= ACK;
                    wbs_ack_o <= alive & wbs_cyc_i;
                    wbs_dat_o <= {mem_rdata_i, rbuf[31:8]};
                end
                ACK: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_prog_loader.sv
// tb_wb_prog_loader: scoreboard bench with a byte-array reference model of the loader
module tb_wb_prog_loader;

    localparam int AW = 11;
    localparam logic [31:0] CTRL = 32'h0001_0000;
    localparam logic [31:0] STAT = 32'h0001_0004;

    logic clk = 1'b0, resetb = 1'b0;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0] sel = '0;
    logic [31:0] adr = '0, dat = '0;
    logic ack;
    logic [31:0] rdat;
    logic mem_en, mem_we, core_rst_n;
    logic [AW-1:0] mem_addr, core_addr = '0;
    logic [7:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    wb_prog_loader #(.ADDR_W(AW)) dut (
        .wb_clk_i(clk), .resetb(resetb),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .core_addr_i(core_addr), .core_rst_n_o(core_rst_n)
    );

    logic [7:0] ram [2048];
    always @(posedge clk) if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {bit rd; logic [31:0] data; int lat;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, failures = 0, cnt = 0, start = 0;
    logic [7:0] mdl [2048];
    bit m_run = 0, m_viol = 0, rst_at_ack, en_seen;

    always @(posedge clk) cnt <= cnt + 1;
    always @(negedge clk) if (mem_en) en_seen = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a 32-bit bus access against a byte array and two flags
    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output exp_t x);
        int off = int'(a[23:0]);
        x.rd = !w; x.data = '0; x.lat = 1;
        if (off < 2048) begin
            if (m_run) m_viol = 1;
            else begin
                x.lat = w ? 5 : 6;
                for (int i = 0; i < 4; i++) begin
                    int b = (off & ~3) + i;
                    if (w && s[i]) mdl[b] = d[8*i +: 8];
                    x.data[8*i +: 8] = mdl[b];
                end
            end
        end else if (off == int'(CTRL[23:0])) begin
            x.data = {31'd0, m_run};
            if (w && s[0]) m_run = d[0];
        end else if (off == int'(STAT[23:0])) begin
            x.data = {30'd0, m_viol, m_run};
            if (w && s[0] && d[1]) m_viol = 0;
        end
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t x;
        int n;
        model(w, a, d, s, x);
        q.push_back(x);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s; start = cnt;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 20);
        if (!ack) begin
            checks++; failures++;
            $display("FAIL ack_timeout adr=%h: no ack after %0d cycles, required one", a, n);
            void'(q.pop_back());
        end
        rst_at_ack = core_rst_n;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    always @(negedge clk) if (resetb && ack) begin
        if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_ack: got ack at cycle %0d, required none", cnt);
        end else begin
            e = q.pop_front();
            chk("ack_latency", cnt - start, e.lat);
            if (e.rd) chk("read_data", rdat, e.data);
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_en", mem_en, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_core", core_rst_n, 0);
    endtask

    initial begin
        exp_t x;
        int bad, first;
        for (int i = 0; i < 2048; i++) begin ram[i] = 0; mdl[i] = 0; end
        #2 chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1 resetb = 1;

        xfer(1, 32'h004, 32'h4433_2211, 4'hF);
        chk("ram_4_7", {ram[7], ram[6], ram[5], ram[4]}, 32'h4433_2211);
        xfer(0, 32'h004, 0, 4'hF);
        xfer(1, 32'h000, 32'hAABB_CCDD, 4'b0101);
        chk("ram_0_3", {ram[3], ram[2], ram[1], ram[0]}, 32'h00BB_00DD);
        xfer(0, 32'h000, 0, 4'hF);

        xfer(1, CTRL, 32'h1, 4'hF);
        chk("core_rst_during_ack", rst_at_ack, 0);
        chk("core_rst_after_run", core_rst_n, 1);
        core_addr = 11'h3F5;
        #1;
        chk("run_addr", mem_addr, 11'h3F5);
        chk("run_en", mem_en, 1);
        xfer(1, 32'h010, 32'hDEAD_BEEF, 4'hF);
        chk("run_we", mem_we, 0);
        xfer(0, 32'h010, 0, 4'hF);
        xfer(0, STAT, 0, 4'hF);
        xfer(1, STAT, 32'h2, 4'hF);
        xfer(0, STAT, 0, 4'hF);
        xfer(0, CTRL, 0, 4'hF);
        xfer(1, CTRL, 32'h0, 4'hF);
        chk("core_rst_ack_clear", rst_at_ack, 1);
        chk("core_rst_after_clear", core_rst_n, 0);
        core_addr = '0;

        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h004; sel = 4'hF;
        repeat (3) @(posedge clk);
        #2 resetb = 0;
        #1 chk_reset_outputs();
        cyc = 0; stb = 0;
        m_run = 0; m_viol = 0;
        repeat (2) @(posedge clk);
        #1 resetb = 1;
        xfer(0, 32'h004, 0, 4'hF);

        en_seen = 0;
        xfer(0, 32'h0002_0000, 0, 4'hF);
        chk("unmapped_no_en", en_seen, 0);

        model(1, 32'h008, 32'h1234_5678, 4'hF, x);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h008; dat = 32'h1234_5678; sel = 4'hF;
        repeat (2) @(posedge clk);
        #1 cyc = 0; stb = 0; we = 0;
        repeat (8) @(posedge clk);
        xfer(0, 32'h008, 0, 4'hF);

        for (int k = 0; k < 150; k++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0) xfer(0, STAT, 0, 4'hF);
            else if (kind == 1) xfer(1'($urandom_range(0, 1)), 32'h0002_0000 | 32'($urandom_range(0, 255) * 4), $urandom, 4'hF);
            else xfer(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511) * 4 + $urandom_range(0, 3)),
                      $urandom, 4'($urandom_range(0, 15)));
        end

        repeat (5) @(posedge clk);
        bad = 0; first = -1;
        for (int i = 0; i < 2048; i++) if (ram[i] !== mdl[i]) begin
            bad++;
            if (first < 0) first = i;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ram_image: %0d bytes differ, first at %0d got %h expected %h", bad, first, ram[first], mdl[first]);
        end
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
